mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 128-bit line-fill memory port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs).
- Sits between both cache controllers and the memory/bus interface; each cache sees a private mem_r/mem_addr/mem_ready/mem_data style port.
- Registered grant FSM with a release gap and a per-transaction timeout watchdog.

Parameters:
- ADDR_W, 32, address width of all address ports.
- LINE_W, 128, cache line width in bits.
- TIMEOUT, 255, max cycles from memory request to mem_ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  reset, synchronous, active-low.
- i_req  in  1  I-cache line-fill request, level, held until i_ready.
- i_addr  in  ADDR_W  I-cache line address; bits [3:0] ignored.
- i_ready  out  1  one-cycle pulse: i_data valid / transaction done.
- i_data  out  LINE_W  fill data to I-cache.
- d_req  in  1  D-cache request, level, held until d_ready.
- d_we  in  1  1 = write-back, 0 = line fill; sampled with d_req.
- d_addr  in  ADDR_W  D-cache line address; bits [3:0] ignored.
- d_wdata  in  LINE_W  write-back data.
- d_ready  out  1  one-cycle pulse: done / d_data valid for reads.
- d_data  out  LINE_W  fill data to D-cache.
- mem_r  out  1  memory read strobe, level, held until mem_ready.
- mem_w  out  1  memory write strobe, level, held until mem_ready.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:4], 4'b0} of granted requester.
- mem_wdata  out  LINE_W  write data (D-cache write-back only).
- mem_ready  in  1  one-cycle completion pulse from memory.
- mem_data  in  LINE_W  read data, valid in the mem_ready cycle.
- grant  out  2  one-hot {D,I} owner of the port; 2'b00 when idle.
- timeout_err  out  1  sticky; set on watchdog abort, cleared only by reset.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; mem_r, mem_w, i_ready, d_ready, grant, timeout_err = 0; mem_addr, mem_wdata, i_data, d_data = 0; wdog = 0; last-grant pointer = I.
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE: if d_req -> BUSY_D (D priority); else if i_req -> BUSY_I. Address, d_we, d_wdata captured into registers on the transition; mem_r/mem_w assert the following cycle (1-cycle request latency). Requester inputs are ignored outside IDLE.
- BUSY_x: mem_r (or mem_w when a latched d_we=1) held high with a stable address; wdog increments each cycle.
- On mem_ready in BUSY_x: strobes drop next cycle, ready_x pulses for exactly one cycle; for reads, data_x <= mem_data (registered, valid with the pulse and held until the next grant) -> RELEASE.
- mem_ready outside BUSY_x: ignored, no ready pulse.
- RELEASE: exactly one cycle, grant=00, no arbitration, so the requester can drop its req after seeing ready -> IDLE. Back-to-back throughput: one transaction per (memory latency + 3) cycles.
- Watchdog (TIMEOUT>0): when wdog reaches TIMEOUT in BUSY_x without mem_ready, the strobes drop, ready_x pulses with data_x = 0, timeout_err <= 1 -> RELEASE. mem_ready in the same cycle as the timeout wins (normal completion).
- wdog clears on every entry to BUSY_x. Width is clog2(TIMEOUT+1).
- Simultaneous i_req and d_req in IDLE: D granted. I is then granted on the next IDLE if d_req has been dropped (see Optional Feature).
- Requester dropping req mid-transaction: the transaction completes and the ready pulse is still issued.
- Reset mid-transaction: FSM returns to IDLE and the strobes drop at once. The in-flight memory response is discarded.
- Fixed-priority starvation of I is accepted without the optional feature.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: in IDLE with both requests pending, grant goes to the requester not served last (last-grant pointer updates on each completion or timeout). A single pending request is granted regardless of the pointer.
- Undefined: fixed D-over-I priority; the pointer register is not present.

Test Plan:
- Reset then i_req=1, i_addr=0x0040_1234, memory answers 4 cycles after mem_r -> mem_addr=0x0040_1230, mem_r high 4 cycles, i_ready pulse 1 cycle with i_data=mem_data, grant=01 then 00.
- d_req=1, d_we=1, d_addr=0x1000_0008, d_wdata=128'hA5..A5 -> mem_w=1, mem_addr=0x1000_0000, mem_wdata=A5..A5, mem_r=0, d_ready pulse, d_data unchanged.
- i_req and d_req rise in the same cycle, both held -> macro off: D served first, I served after RELEASE; macro on with last grant=D: I served first.
- TIMEOUT=8, memory never answers -> strobe high for 8 cycles, then ready pulse with data=0, timeout_err=1 and stays 1 through later good transactions.
- rst=0 for one cycle while BUSY_D with mem_w high -> next cycle mem_w=0, grant=00; a late mem_ready produces no d_ready.
- Requester keeps req high one cycle after its ready pulse -> no duplicate grant in RELEASE; a re-request only if req is still high in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 128-bit line-fill memory port between the
// I-cache (read fills) and the D-cache (fills and write-backs).
// Registered grant FSM with a one-cycle release gap and a per-transaction
// timeout watchdog (TIMEOUT = 0 disables it).
// Build option: define ARB_ROUND_ROBIN_EN to alternate the grant when both
// caches request together; otherwise the D-cache always has priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [LINE_W-1:0] i_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [LINE_W-1:0] d_data,
    output logic              mem_r,
    output logic              mem_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_data,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    localparam int unsigned WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_I  = 2'd1;
    localparam logic [1:0] S_BUSY_D  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [1:0]        grant_nxt;
    logic              mem_r_nxt, mem_w_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [LINE_W-1:0] mem_wdata_nxt;
    logic              we_q, we_nxt;
    logic              i_ready_nxt, d_ready_nxt;
    logic [LINE_W-1:0] i_data_nxt, d_data_nxt;
    logic              timeout_err_nxt;
    logic [WDOG_W-1:0] wdog, wdog_nxt;
    logic              strobe;
    logic              wdog_hit;
    logic              pick_d;

    // Line offset bits are don't-care on both request ports.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr[3:0], d_addr[3:0]};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d, last_d_nxt;

    // Contention goes to whichever cache was not served last.
    assign pick_d = d_req && (!i_req || !last_d);
`else
    // Fixed D-over-I priority.
    assign pick_d = d_req;
`endif

    assign strobe   = mem_r | mem_w;
    assign wdog_hit = (TIMEOUT > 0) && (wdog == WDOG_W'(TIMEOUT - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant;
        mem_r_nxt       = mem_r;
        mem_w_nxt       = mem_w;
        mem_addr_nxt    = mem_addr;
        mem_wdata_nxt   = mem_wdata;
        we_nxt          = we_q;
        i_ready_nxt     = 1'b0;
        d_ready_nxt     = 1'b0;
        i_data_nxt      = i_data;
        d_data_nxt      = d_data;
        timeout_err_nxt = timeout_err;
        wdog_nxt        = wdog;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_nxt      = last_d;
`endif
        case (state)
            S_IDLE: begin
                if (pick_d) begin
                    state_nxt     = S_BUSY_D;
                    grant_nxt     = 2'b10;
                    mem_addr_nxt  = {d_addr[ADDR_W-1:4], 4'b0};
                    mem_wdata_nxt = d_wdata;
                    we_nxt        = d_we;
                    wdog_nxt      = '0;
                end else if (i_req) begin
                    state_nxt    = S_BUSY_I;
                    grant_nxt    = 2'b01;
                    mem_addr_nxt = {i_addr[ADDR_W-1:4], 4'b0};
                    we_nxt       = 1'b0;
                    wdog_nxt     = '0;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (!strobe) begin
                    // First busy cycle: raise the strobe one cycle after the grant.
                    mem_r_nxt = !we_q;
                    mem_w_nxt = we_q;
                end else if (mem_ready || wdog_hit) begin
                    // Completion beats a same-cycle timeout.
                    mem_r_nxt = 1'b0;
                    mem_w_nxt = 1'b0;
                    grant_nxt = 2'b00;
                    state_nxt = S_RELEASE;
                    if (!mem_ready) begin
                        timeout_err_nxt = 1'b1;
                    end
                    if (state == S_BUSY_I) begin
                        i_ready_nxt = 1'b1;
                        i_data_nxt  = mem_ready ? mem_data : '0;
                    end else begin
                        d_ready_nxt = 1'b1;
                        if (!mem_ready) begin
                            d_data_nxt = '0;
                        end else if (!we_q) begin
                            d_data_nxt = mem_data;
                        end
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_nxt = (state == S_BUSY_D);
`endif
                end else if (TIMEOUT > 0) begin
                    wdog_nxt = wdog + WDOG_W'(1);
                end
            end
            default: begin
                // Release gap: no arbitration so the requester can drop req.
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            grant       <= 2'b00;
            mem_r       <= 1'b0;
            mem_w       <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            we_q        <= 1'b0;
            i_ready     <= 1'b0;
            d_ready     <= 1'b0;
            i_data      <= '0;
            d_data      <= '0;
            timeout_err <= 1'b0;
            wdog        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d      <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            grant       <= grant_nxt;
            mem_r       <= mem_r_nxt;
            mem_w       <= mem_w_nxt;
            mem_addr    <= mem_addr_nxt;
            mem_wdata   <= mem_wdata_nxt;
            we_q        <= we_nxt;
            i_ready     <= i_ready_nxt;
            d_ready     <= d_ready_nxt;
            i_data      <= i_data_nxt;
            d_data      <= d_data_nxt;
            timeout_err <= timeout_err_nxt;
            wdog        <= wdog_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            last_d      <= last_d_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: scoreboard of expected transactions,
// a small memory responder task, and one task per scenario.
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, i_ready;
    logic [31:0]  i_addr;
    logic [127:0] i_data;
    logic         d_req, d_we, d_ready;
    logic [31:0]  d_addr;
    logic [127:0] d_wdata, d_data;
    logic         mem_r, mem_w, mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_data;
    logic [1:0]   grant;
    logic         timeout_err;

    localparam logic [127:0] GARBAGE = {4{32'hDEADBEEF}};

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit           is_d;
        logic [31:0]  addr;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];

    // Observations recorded by the memory responder.
    bit           obs_seen;
    int           obs_wait, obs_cnt;
    logic [31:0]  obs_addr;
    logic         obs_r, obs_w, obs_iry, obs_dry, obs_terr;
    logic [127:0] obs_wdata, obs_idata, obs_ddata;
    logic [1:0]   obs_gbusy, obs_gdone;

    mem_port_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_data(d_data),
        .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_data(mem_data),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input bit is_d, input logic [31:0] a, input logic [127:0] d);
        exp_t e;
        e.is_d = is_d;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Memory model: wait for a strobe, answer lat strobe-cycles later (lat=0: never).
    // Returns at the negedge after the strobe drops, i.e. in the ready-pulse cycle.
    task automatic serve(input int lat, input logic [127:0] rd);
        obs_seen = 1'b0;
        obs_wait = 0;
        obs_cnt  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            obs_wait++;
            if (mem_r || mem_w) begin
                obs_seen = 1'b1;
                break;
            end
        end
        if (!obs_seen) return;
        obs_addr  = mem_addr;
        obs_r     = mem_r;
        obs_w     = mem_w;
        obs_wdata = mem_wdata;
        obs_gbusy = grant;
        obs_cnt   = 1;
        for (int k = 0; k < 300; k++) begin
            if (lat > 0 && obs_cnt == lat) begin
                mem_ready = 1'b1;
                mem_data  = rd;
            end
            @(negedge clk);
            mem_ready = 1'b0;
            mem_data  = GARBAGE;
            if (mem_r || mem_w) obs_cnt++;
            else break;
        end
        obs_iry   = i_ready;
        obs_dry   = d_ready;
        obs_idata = i_data;
        obs_ddata = d_data;
        obs_gdone = grant;
        obs_terr  = timeout_err;
    endtask

    task automatic test_reset();
        checks++;
        if ({mem_r, mem_w, i_ready, d_ready, timeout_err, grant} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0", {mem_r, mem_w, i_ready, d_ready, timeout_err, grant});
        end
        checks++;
        if ({mem_addr, mem_wdata, i_data, d_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h nonzero data, want all 0", mem_addr);
        end
    endtask

    task automatic test_ifill();
        exp_t e;
        i_addr = 32'h0040_1234;
        i_req  = 1'b1;
        push_exp(1'b0, 32'h0040_1230, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        serve(4, sb[0].data);
        i_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs_seen !== 1'b1 || obs_wait !== 2) begin
            errors++;
            $display("FAIL ifill_latency: got seen=%0d wait=%0d want 1/2", obs_seen, obs_wait);
        end
        checks++;
        if (obs_addr !== e.addr || {obs_r, obs_w} !== 2'b10) begin
            errors++;
            $display("FAIL ifill_req: got %h rw=%b want %h rw=10", obs_addr, {obs_r, obs_w}, e.addr);
        end
        checks++;
        if (obs_cnt !== 4 || obs_gbusy !== 2'b01) begin
            errors++;
            $display("FAIL ifill_strobe: got cycles=%0d grant=%b want 4/01", obs_cnt, obs_gbusy);
        end
        checks++;
        if ({obs_iry, obs_dry, obs_gdone} !== 4'b1000 || obs_idata !== e.data) begin
            errors++;
            $display("FAIL ifill_done: got rdy=%b grant=%b data=%h want 10/00 %h",
                     {obs_iry, obs_dry}, obs_gdone, obs_idata, e.data);
        end
        @(negedge clk);
        checks++;
        if (i_ready !== 1'b0 || i_data !== e.data) begin
            errors++;
            $display("FAIL ifill_pulse: got rdy=%b data=%h want 0 %h", i_ready, i_data, e.data);
        end
    endtask

    task automatic test_dfill_edge();
        exp_t e;
        d_addr = 32'h2000_00FF;
        d_we   = 1'b0;
        d_req  = 1'b1;
        push_exp(1'b1, 32'h2000_00F0, {4{32'hC0FF_EE11}});
        serve(8, sb[0].data);
        d_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs_addr !== e.addr || obs_cnt !== 8 || obs_gbusy !== 2'b10) begin
            errors++;
            $display("FAIL dfill_edge_req: got %h cycles=%0d grant=%b want %h 8 10",
                     obs_addr, obs_cnt, obs_gbusy, e.addr);
        end
        checks++;
        if (obs_dry !== 1'b1 || obs_ddata !== e.data || obs_terr !== 1'b0) begin
            errors++;
            $display("FAIL dfill_edge_done: got rdy=%b data=%h err=%b want 1 %h 0",
                     obs_dry, obs_ddata, obs_terr, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_dwb(input logic [127:0] prev_d);
        exp_t e;
        d_addr  = 32'h1000_0008;
        d_we    = 1'b1;
        d_wdata = {16{8'hA5}};
        d_req   = 1'b1;
        push_exp(1'b1, 32'h1000_0000, prev_d);
        serve(3, 128'h5555);
        d_req = 1'b0;
        d_we  = 1'b0;
        e = sb.pop_front();
        checks++;
        if ({obs_r, obs_w} !== 2'b01 || obs_addr !== e.addr || obs_wdata !== {16{8'hA5}}) begin
            errors++;
            $display("FAIL dwb_req: got rw=%b %h %h want 01 %h A5..", {obs_r, obs_w}, obs_addr, obs_wdata, e.addr);
        end
        checks++;
        if ({obs_dry, obs_iry} !== 2'b10 || obs_ddata !== e.data) begin
            errors++;
            $display("FAIL dwb_done: got rdy=%b d_data=%h want 10 %h", {obs_dry, obs_iry}, obs_ddata, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_both();
        exp_t e;
        i_addr = 32'h0000_1110;
        d_addr = 32'h0000_2220;
        d_we   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 32'h0000_1110, {4{32'h1111_AAAA}});
        push_exp(1'b1, 32'h0000_2220, {4{32'h2222_BBBB}});
`else
        push_exp(1'b1, 32'h0000_2220, {4{32'h2222_BBBB}});
        push_exp(1'b0, 32'h0000_1110, {4{32'h1111_AAAA}});
`endif
        i_req = 1'b1;
        d_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            serve(3, sb[0].data);
            e = sb.pop_front();
            if (e.is_d) d_req = 1'b0;
            else        i_req = 1'b0;
            checks++;
            if (obs_addr !== e.addr || obs_gbusy !== (e.is_d ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL both_order%0d: got %h grant=%b want %h d=%0d", k, obs_addr, obs_gbusy, e.addr, e.is_d);
            end
            checks++;
            if ({obs_dry, obs_iry} !== (e.is_d ? 2'b10 : 2'b01) ||
                (e.is_d ? obs_ddata : obs_idata) !== e.data) begin
                errors++;
                $display("FAIL both_done%0d: got rdy=%b want d=%0d data %h", k, {obs_dry, obs_iry}, e.is_d, e.data);
            end
            if (k == 1) begin
                checks++;
                if (obs_wait !== 3) begin
                    errors++;
                    $display("FAIL both_gap: got %0d want 3", obs_wait);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        exp_t e;
        i_addr = 32'h3000_0010;
        i_req  = 1'b1;
        push_exp(1'b0, 32'h3000_0010, '0);
        serve(0, '0);
        i_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs_cnt !== 8 || obs_addr !== e.addr) begin
            errors++;
            $display("FAIL timeout_len: got %0d cycles %h want 8 %h", obs_cnt, obs_addr, e.addr);
        end
        checks++;
        if (obs_iry !== 1'b1 || obs_idata !== e.data || obs_terr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: got rdy=%b data=%h err=%b want 1 0 1", obs_iry, obs_idata, obs_terr);
        end
        @(negedge clk);
        d_addr = 32'h3000_0020;
        d_we   = 1'b0;
        d_req  = 1'b1;
        push_exp(1'b1, 32'h3000_0020, {4{32'h7777_0001}});
        serve(2, sb[0].data);
        d_req = 1'b0;
        e = sb.pop_front();
        checks++;
        if (obs_dry !== 1'b1 || obs_ddata !== e.data || obs_terr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got rdy=%b data=%h err=%b want 1 %h 1", obs_dry, obs_ddata, obs_terr, e.data);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen, late;
        seen   = 1'b0;
        late   = 1'b0;
        d_addr = 32'h4000_0000;
        d_we   = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_w) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rstmid_strobe: got no mem_w want mem_w=1");
        end
        rst   = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if ({mem_r, mem_w, grant, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_drop: got %b want 00000", {mem_r, mem_w, grant, timeout_err});
        end
        mem_ready = 1'b1;
        mem_data  = {4{32'h9999_9999}};
        @(negedge clk);
        mem_ready = 1'b0;
        mem_data  = GARBAGE;
        for (int k = 0; k < 4; k++) begin
            if (d_ready || i_ready || grant != 2'b00) late = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (late) begin
            errors++;
            $display("FAIL rstmid_late: got ready/grant after late mem_ready want none");
        end
    endtask

    task automatic test_hold_req();
        bit extra;
        extra  = 1'b0;
        i_addr = 32'h5000_0040;
        i_req  = 1'b1;
        push_exp(1'b0, 32'h5000_0040, {4{32'h0BAD_F00D}});
        serve(2, sb[0].data);
        void'(sb.pop_front());
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got grant=%b rdy=%b want 00 0", grant, i_ready);
        end
        i_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (grant != 2'b00 || mem_r || mem_w) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL hold_nodup: got duplicate grant want none");
        end
        i_req = 1'b1;
        push_exp(1'b0, 32'h5000_0040, {4{32'h1357_2468}});
        push_exp(1'b0, 32'h5000_0040, {4{32'h8642_7531}});
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            serve(2, sb[0].data);
            e = sb.pop_front();
            checks++;
            if (obs_iry !== 1'b1 || obs_idata !== e.data || (k == 1 && obs_wait !== 3)) begin
                errors++;
                $display("FAIL hold_rereq%0d: got rdy=%b data=%h wait=%0d want 1 %h", k, obs_iry, obs_idata, obs_wait, e.data);
            end
        end
        i_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ready = 1'b0;
        mem_data  = GARBAGE;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_ifill();
        test_dfill_edge();
        test_dwb({4{32'hC0FF_EE11}});
        test_both();
        test_timeout();
        test_reset_mid();
        test_hold_req();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
